// File: rtl/dmem_pkg.sv
// ============================================================================
// dmem_pkg : shared encodings and default widths for the data-memory arbiter
// Revision : 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

  typedef logic [0:0] arb_state_t;
  typedef logic [0:0] req_id_t;

  localparam arb_state_t ST_ARB   = 1'b0;
  localparam arb_state_t ST_LOCKB = 1'b1;

  localparam req_id_t REQ_A = 1'b0;
  localparam req_id_t REQ_B = 1'b1;

  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_MAX_WAIT = 4;
  localparam int DEF_WAIT_W   = 3;

endpackage

`default_nettype wire

// File: rtl/dmem_arb_pick.sv
// ============================================================================
// dmem_arb_pick : combinational grant decision (B priority, A promotion, B lock)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module dmem_arb_pick
  import dmem_pkg::*;
(
  input  logic       i_a_req,
  input  logic       i_b_req,
  input  arb_state_t i_state,
  input  logic       i_promote,
  output logic       o_gnt_a,
  output logic       o_gnt_b
);

  logic w_arb;
  logic w_a_wins;

  assign w_arb = (i_state == ST_ARB);

  // Promotion only matters while arbitrating; a B lock shuts A out entirely.
  assign w_a_wins = w_arb & i_a_req & (i_promote | ~i_b_req);

  assign o_gnt_a = w_a_wins;
  assign o_gnt_b = i_b_req & ~w_a_wins;

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : shares the single-port data memory between MEM stage (A) and
//                the interrupt sequencer (B). Macro DMEM_ARB_STARVE_GUARD_EN
//                builds the A anti-starvation counter.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int WAIT_W   = DEF_WAIT_W
) (
  input  logic              clk,
  input  logic              reset_b,

  input  logic              i_a_req,
  input  logic              i_a_we,
  input  logic              i_a_en32,
  input  logic              i_a_isStack,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_wdata,
  output logic              o_a_gnt,
  output logic              o_a_rvalid,
  output logic [DATA_W-1:0] o_a_rdata,

  input  logic              i_b_req,
  input  logic              i_b_we,
  input  logic              i_b_en32,
  input  logic              i_b_isStack,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_wdata,
  input  logic              i_b_lock,
  output logic              o_b_gnt,
  output logic              o_b_rvalid,
  output logic [DATA_W-1:0] o_b_rdata,

  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic              o_mem_en32,
  output logic              o_mem_isStack,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  arb_state_t state_q, state_d;
  logic       rvalid_q, rvalid_d;
  req_id_t    owner_q, owner_d;

  logic w_a_req;
  logic w_b_req;
  logic w_gnt_a;
  logic w_gnt_b;
  logic w_promote;

  // Requests are masked during reset so grants and memory strobes stay low.
  assign w_a_req = i_a_req & reset_b;
  assign w_b_req = i_b_req & reset_b;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  logic [WAIT_W-1:0] wait_q, wait_d;

  always_comb begin
    wait_d = wait_q;
    if (!w_a_req || w_gnt_a) begin
      wait_d = '0;
    end else if (wait_q < WAIT_W'(MAX_WAIT)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign w_promote = (wait_q == WAIT_W'(MAX_WAIT));
`else
  logic [WAIT_W-1:0] w_unused_wait;
  assign w_unused_wait = WAIT_W'(MAX_WAIT);
  assign w_promote     = 1'b0;
`endif

  dmem_arb_pick u_pick (
    .i_a_req   (w_a_req),
    .i_b_req   (w_b_req),
    .i_state   (state_q),
    .i_promote (w_promote),
    .o_gnt_a   (w_gnt_a),
    .o_gnt_b   (w_gnt_b)
  );

  assign o_a_gnt = w_gnt_a;
  assign o_b_gnt = w_gnt_b;

  always_comb begin
    state_d = state_q;
    if (w_gnt_b) begin
      state_d = i_b_lock ? ST_LOCKB : ST_ARB;
    end
  end

  assign rvalid_d = (w_gnt_a & ~i_a_we) | (w_gnt_b & ~i_b_we);
  assign owner_d  = w_gnt_b ? REQ_B : REQ_A;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q  <= ST_ARB;
      rvalid_q <= 1'b0;
      owner_q  <= REQ_A;
    end else begin
      state_q  <= state_d;
      rvalid_q <= rvalid_d;
      owner_q  <= owner_d;
    end
  end

  always_comb begin
    o_mem_read    = 1'b0;
    o_mem_write   = 1'b0;
    o_mem_en32    = 1'b0;
    o_mem_isStack = 1'b0;
    o_mem_addr    = '0;
    o_mem_wdata   = '0;
    if (w_gnt_b) begin
      o_mem_read    = ~i_b_we;
      o_mem_write   = i_b_we;
      o_mem_en32    = i_b_en32;
      o_mem_isStack = i_b_isStack;
      o_mem_addr    = i_b_addr;
      o_mem_wdata   = i_b_wdata;
    end else if (w_gnt_a) begin
      o_mem_read    = ~i_a_we;
      o_mem_write   = i_a_we;
      o_mem_en32    = i_a_en32;
      o_mem_isStack = i_a_isStack;
      o_mem_addr    = i_a_addr;
      o_mem_wdata   = i_a_wdata;
    end
  end

  assign o_a_rvalid = rvalid_q & (owner_q == REQ_A);
  assign o_b_rvalid = rvalid_q & (owner_q == REQ_B);
  assign o_a_rdata  = o_a_rvalid ? i_mem_rdata : '0;
  assign o_b_rdata  = o_b_rvalid ? i_mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// tb_dmem_arbiter : directed stimulus with a read-return scoreboard for dmem_arbiter
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  localparam logic [31:0] RD_KEY = 32'hA5A5_0000;
  localparam logic [31:0] IDLE_RD = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        i_a_req, i_a_we, i_a_en32, i_a_isStack;
  logic [31:0] i_a_addr, i_a_wdata;
  logic        o_a_gnt, o_a_rvalid;
  logic [31:0] o_a_rdata;
  logic        i_b_req, i_b_we, i_b_en32, i_b_isStack, i_b_lock;
  logic [31:0] i_b_addr, i_b_wdata;
  logic        o_b_gnt, o_b_rvalid;
  logic [31:0] o_b_rdata;
  logic        o_mem_read, o_mem_write, o_mem_en32, o_mem_isStack;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [31:0] i_mem_rdata = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  typedef struct {
    logic        port;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset_b(reset_b),
    .i_a_req(i_a_req), .i_a_we(i_a_we), .i_a_en32(i_a_en32), .i_a_isStack(i_a_isStack),
    .i_a_addr(i_a_addr), .i_a_wdata(i_a_wdata),
    .o_a_gnt(o_a_gnt), .o_a_rvalid(o_a_rvalid), .o_a_rdata(o_a_rdata),
    .i_b_req(i_b_req), .i_b_we(i_b_we), .i_b_en32(i_b_en32), .i_b_isStack(i_b_isStack),
    .i_b_addr(i_b_addr), .i_b_wdata(i_b_wdata), .i_b_lock(i_b_lock),
    .o_b_gnt(o_b_gnt), .o_b_rvalid(o_b_rvalid), .o_b_rdata(o_b_rdata),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_en32(o_mem_en32),
    .o_mem_isStack(o_mem_isStack), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata)
  );

  // Memory model: read data is a fixed function of the address, one cycle later.
  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (o_mem_read) i_mem_rdata <= o_mem_addr ^ RD_KEY;
    else            i_mem_rdata <= IDLE_RD;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    chk("rvalid_exclusive", 32'(o_a_rvalid & o_b_rvalid), 32'h0);
    if (o_a_rvalid || o_b_rvalid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_rvalid: got a=%0b b=%0b expected none", o_a_rvalid, o_b_rvalid);
      end else begin
        e = sb.pop_front();
        chk("rv_port",  32'(o_b_rvalid), 32'(e.port));
        chk("rv_cycle", 32'(cyc_n), 32'(e.due));
        chk("rv_data",  o_b_rvalid ? o_b_rdata : o_a_rdata, e.data);
        chk("rv_other_rdata", o_b_rvalid ? o_a_rdata : o_b_rdata, 32'h0);
      end
    end else begin
      chk("rdata_idle", o_a_rdata | o_b_rdata, 32'h0);
      if (sb.size() > 0 && sb[0].due <= cyc_n) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_rvalid: got none expected port %0b at cycle %0d", sb[0].port, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  // One cycle: drive at negedge, check combinational grant/mux, let the posedge accept.
  task automatic cyc(input logic ar, input logic aw, input logic [31:0] aad,
                     input logic br, input logic bw, input logic bl, input logic [31:0] bad,
                     input logic ega, input logic egb, input string tag);
    logic [3:0]  ectl;
    logic [31:0] ead, ewd;
    i_a_req = ar; i_a_we = aw; i_a_addr = aad; i_a_wdata = aad ^ 32'h5555_0000;
    i_b_req = br; i_b_we = bw; i_b_lock = bl; i_b_addr = bad; i_b_wdata = bad ^ 32'h0000_3333;
    #1;
    ectl = 4'b0000; ead = 32'h0; ewd = 32'h0;
    if (ega) begin
      ectl = {~aw, aw, 1'b0, 1'b1}; ead = aad; ewd = aad ^ 32'h5555_0000;
    end else if (egb) begin
      ectl = {~bw, bw, 1'b1, 1'b0}; ead = bad; ewd = bad ^ 32'h0000_3333;
    end
    chk({tag, " a_gnt"}, 32'(o_a_gnt), 32'(ega));
    chk({tag, " b_gnt"}, 32'(o_b_gnt), 32'(egb));
    chk({tag, " mem_ctl"}, 32'({o_mem_read, o_mem_write, o_mem_en32, o_mem_isStack}), 32'(ectl));
    chk({tag, " mem_addr"}, o_mem_addr, ead);
    chk({tag, " mem_wdata"}, o_mem_wdata, ewd);
    if (ega && !aw) sb.push_back('{1'b0, aad ^ RD_KEY, cyc_n + 1});
    if (egb && !bw) sb.push_back('{1'b1, bad ^ RD_KEY, cyc_n + 1});
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, "idle");
  endtask

  initial begin
    reset_b = 1'b0;
    i_a_req = 0; i_a_we = 0; i_a_en32 = 1'b0; i_a_isStack = 1'b1; i_a_addr = 0; i_a_wdata = 0;
    i_b_req = 0; i_b_we = 0; i_b_en32 = 1'b1; i_b_isStack = 1'b0; i_b_addr = 0; i_b_wdata = 0;
    i_b_lock = 0;
    repeat (2) @(negedge clk);
    i_a_req = 1'b1; i_b_req = 1'b1; i_a_addr = 32'h44; i_b_addr = 32'h88;
    #1;
    chk("rst a_gnt", 32'(o_a_gnt), 32'h0);
    chk("rst b_gnt", 32'(o_b_gnt), 32'h0);
    chk("rst mem_ctl", 32'({o_mem_read, o_mem_write, o_mem_en32, o_mem_isStack}), 32'h0);
    chk("rst mem_addr", o_mem_addr, 32'h0);
    chk("rst rvalid", 32'({o_a_rvalid, o_b_rvalid}), 32'h0);
    i_a_req = 1'b0; i_b_req = 1'b0;
    reset_b = 1'b1;
    @(negedge clk);

    cyc(1'b1, 1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, "a_alone");
    idle();

    // Contention: B wins until A has waited MAX_WAIT cycles (when guarded).
    for (int i = 0; i < 6; i++) begin
      logic ega;
      ega = GUARD && (i == 4);
      cyc(1'b1, 1'b0, 32'h100 + i, 1'b1, 1'b0, 1'b0, 32'h200 + i, ega, !ega, "both");
    end
    idle();

    // B stack sequence under lock while A keeps requesting.
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b0, 32'h300 + i, 1'b1, 1'b0, 1'b0, 32'h310 + i, 1'b0, 1'b1, "pre_lock");
    cyc(1'b1, 1'b0, 32'h320, 1'b1, 1'b1, 1'b1, 32'h330, 1'b0, 1'b1, "pc_lock");
    cyc(1'b1, 1'b0, 32'h321, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, "lock_b_idle");
    cyc(1'b1, 1'b0, 32'h322, 1'b1, 1'b1, 1'b0, 32'h331, 1'b0, 1'b1, "flags_unlock");
    cyc(1'b1, 1'b0, 32'h323, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, "after_lock");
    idle();

    cyc(1'b1, 1'b0, 32'h400, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, "alt_a0");
    cyc(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h500, 1'b0, 1'b1, "alt_b0");
    cyc(1'b1, 1'b0, 32'h401, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, "alt_a1");
    cyc(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h501, 1'b0, 1'b1, "alt_b1");
    idle();

    // Reset while locked with a B read just accepted: the read is dropped.
    i_a_req = 1'b1; i_a_we = 1'b0; i_a_addr = 32'h610;
    i_b_req = 1'b1; i_b_we = 1'b0; i_b_lock = 1'b1; i_b_addr = 32'h600;
    @(posedge clk);
    #1;
    reset_b = 1'b0;
    #1;
    chk("rst_lock a_gnt", 32'(o_a_gnt), 32'h0);
    chk("rst_lock b_gnt", 32'(o_b_gnt), 32'h0);
    chk("rst_lock mem_ctl", 32'({o_mem_read, o_mem_write, o_mem_en32, o_mem_isStack}), 32'h0);
    chk("rst_lock mem_addr", o_mem_addr, 32'h0);
    chk("rst_lock rvalid", 32'({o_a_rvalid, o_b_rvalid}), 32'h0);
    @(negedge clk);
    i_a_req = 1'b0; i_b_req = 1'b0; i_b_lock = 1'b0;
    reset_b = 1'b1;
    @(negedge clk);
    cyc(1'b1, 1'b0, 32'h700, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, "post_rst_arb");
    idle();

    for (int i = 0; i < 20; i++) begin
      logic ega;
      ega = GUARD && ((i % 5) == 4);
      cyc(1'b1, 1'b0, 32'h800 + i, 1'b1, 1'b0, 1'b0, 32'h900 + i, ega, !ega, "starve");
    end
    repeat (3) idle();

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between two requesters.
- Port A: pipeline MEM stage (loads, stores, push, pop).
- Port B: interrupt/exception sequencer (pushes PC and flags, pops on return).
- Fixed B-over-A priority, a B-side lock for multi-beat stack sequences, and an A anti-starvation guard.
- Drives the memory's read/write/en32/isStack/address/data inputs and returns read data to the owning port.

Parameters:
ADDR_W, 32, address width for both ports and memory.
DATA_W, 32, data width for both ports and memory.
MAX_WAIT, 4, consecutive denied A cycles before A is promoted over B.
WAIT_W, 3, width of the wait counter; must satisfy 2**WAIT_W > MAX_WAIT.

Ports:
clk  in  1  system clock; all state changes on posedge.
reset_b  in  1  asynchronous active-low reset.
i_a_req  in  1  A requests one memory beat.
i_a_we  in  1  1 = write, 0 = read.
i_a_en32  in  1  32-bit access.
i_a_isStack  in  1  stack-relative 16-bit read.
i_a_addr  in  ADDR_W  A word address.
i_a_wdata  in  DATA_W  A write data.
o_a_gnt  out  1  A beat accepted this cycle.
o_a_rvalid  out  1  A read data valid.
o_a_rdata  out  DATA_W  A read data.
i_b_req, i_b_we, i_b_en32, i_b_isStack, i_b_addr, i_b_wdata  in  as A  B request fields.
i_b_lock  in  1  B keeps ownership after this beat.
o_b_gnt, o_b_rvalid, o_b_rdata  out  as A  B responses.
o_mem_read  out  1  memory read enable.
o_mem_write  out  1  memory write enable.
o_mem_en32  out  1  memory 32-bit enable.
o_mem_isStack  out  1  memory stack-read flag.
o_mem_addr  out  ADDR_W  memory address.
o_mem_wdata  out  DATA_W  memory write data.
i_mem_rdata  in  DATA_W  memory read data, valid the cycle after the read edge.

Behaviour:
- Reset (async, reset_b=0):
  - state=ARB, wait_cnt=0, rvalid regs and their owner tag = 0.
  - All o_mem_*, gnt and rvalid outputs are 0.
  - A lock or pending read in flight is dropped; no rvalid is issued for it.
- Grant is combinational within the cycle. A beat is accepted when req & gnt at a posedge; the memory samples the same edge.
- Memory outputs mux the granted port's fields:
  - o_mem_write = we; o_mem_read = ~we; en32 and isStack are passed through.
  - With no grant: read=write=0, en32=isStack=0, addr=wdata=0.
- At most one gnt per cycle; o_a_gnt and o_b_gnt are never both 1.
- States:
  - ARB:
    - Default: B wins if i_b_req.
    - Promoted: A wins if i_a_req and wait_cnt==MAX_WAIT.
    - Otherwise the sole requester wins.
    - An accepted B beat with i_b_lock=1 moves state to LOCKB.
  - LOCKB:
    - Only B can be granted; o_a_gnt=0 regardless of promotion.
    - An accepted B beat with i_b_lock=0 returns state to ARB.
    - If B is idle (i_b_req=0), state holds LOCKB and the memory is idle.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) on each cycle with i_a_req & ~o_a_gnt.
  - Clears on an accepted A beat.
  - Clears when i_a_req=0.
- Read return:
  - An accepted read sets rvalid for the owning port for exactly one cycle, the next cycle.
  - o_x_rdata = i_mem_rdata while o_x_rvalid=1; 0 otherwise.
  - Back-to-back reads give rvalid on consecutive cycles with no gap.
- Writes produce no rvalid.
- Latency: grant 0 cycles, read data 1 cycle after acceptance.

Optional Feature:
DMEM_ARB_STARVE_GUARD_EN
- Defined: wait_cnt and A promotion behave as above.
- Undefined: wait_cnt is not built; B always wins in ARB, so A can starve while B requests.
- MAX_WAIT and WAIT_W are ignored when undefined.

Decomposition:
- Shared package dmem_pkg: state encoding (ARB=1'b0, LOCKB=1'b1), requester IDs (REQ_A=0, REQ_B=1), default widths.
- One sub-module: dmem_arb_pick.
  - Combinational grant decision.
  - Inputs: i_a_req, i_b_req, state, promote.
  - Outputs: gnt_a, gnt_b.

Test Plan:
- After reset, A read addr=0x10 alone -> o_a_gnt=1 same cycle, o_mem_read=1, o_mem_addr=0x10; next cycle o_a_rvalid=1, o_a_rdata=i_mem_rdata.
- A and B both request every cycle (guard on, MAX_WAIT=4) -> B granted 4 cycles, A granted 5th cycle, then B again; wait_cnt back to 0.
- B beat 1: 32-bit write PC with i_b_lock=1; beat 2: flags write with lock=0; A requesting throughout -> A denied both beats even at wait_cnt=MAX_WAIT; A granted the cycle after beat 2.
- Alternating A read, B read on consecutive cycles -> o_a_rvalid and o_b_rvalid on consecutive cycles, each with the correct data, never both high.
- reset_b low while in LOCKB with a read just accepted -> all outputs 0 immediately, no rvalid after release, state=ARB.
- Guard compiled out, both ports requesting for 20 cycles -> o_a_gnt=0 throughout.
